inst_rom_loader: RTL and testbench

- Instruction-side responder for the core's fetch port. Accepts the core's chip-enable and byte-address, and returns the 32-bit instruction word in the same cycle.
- Owns the instruction memory array. Includes a byte-serial load port so a boot host can fill the memory while the core is held in reset.
- Sits beside the core at SoC top level.

---
 rtl/inst_rom_loader_pkg.sv | 33 +++
 rtl/inst_rom_loader_mem.sv | 27 ++
 rtl/inst_rom_loader.sv | 152 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
// The helper packs one load byte into a 32-bit word, most significant byte first.
package inst_rom_loader_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2
  } ld_state_e;

  function automatic logic [INST_W-1:0] pack_byte(
    input logic [INST_W-1:0] word,
    input logic [1:0]        idx,
    input logic [BYTE_W-1:0] b
  );
    logic [INST_W-1:0] w_res;
    w_res = word;
    case (idx)
      2'd0:    w_res[31:24] = b;
      2'd1:    w_res[23:16] = b;
      2'd2:    w_res[15:8]  = b;
      2'd3:    w_res[7:0]   = b;
      default: w_res = word;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction memory array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded image survives a core reset.
module inst_mem_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] r_mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch-side instruction responder with a byte-serial boot load port.
// Bytes are packed big-endian into words and written sequentially from word 0.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [INST_W-1:0] inst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [BYTE_W-1:0] ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              busy,
  output logic [ADDR_W:0]   word_cnt
);

  ld_state_e         r_state,    w_state_nxt;
  logic [ADDR_W:0]   r_ptr,      w_ptr_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [INST_W-1:0] r_asm,      w_asm_nxt;
  logic              r_last,     w_last_nxt;
  logic              r_err,      w_err_nxt;
  logic              r_done,     w_done_nxt;
  logic              w_we;
  logic              w_in_range;
  logic [INST_W-1:0] w_rdata;
  logic              w_unused;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LD_IDLE;
      r_ptr      <= '0;
      r_byte_cnt <= 2'd0;
      r_asm      <= ZERO_WORD;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_asm      <= w_asm_nxt;
      r_last     <= w_last_nxt;
      r_err      <= w_err_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic: session start/restart, byte packing and word commit
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_asm_nxt      = r_asm;
    w_last_nxt     = r_last;
    w_err_nxt      = r_err;
    w_done_nxt     = 1'b0;
    w_we           = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (ld_start) begin
          w_state_nxt    = LD_COLLECT;
          w_ptr_nxt      = '0;
          w_byte_cnt_nxt = 2'd0;
          w_asm_nxt      = ZERO_WORD;
          w_last_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
        end else begin
          w_state_nxt = LD_IDLE;
        end
      end
      LD_COLLECT: begin
        // A restart wins over a byte offered in the same cycle
        if (ld_start) begin
          w_ptr_nxt      = '0;
          w_byte_cnt_nxt = 2'd0;
          w_asm_nxt      = ZERO_WORD;
          w_last_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
        end else if (ld_valid) begin
          w_asm_nxt      = pack_byte(r_asm, r_byte_cnt, ld_byte);
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_last_nxt     = ld_last;
          if (ld_last || (r_byte_cnt == 2'd3)) begin
            w_state_nxt = LD_WRITE;
          end else begin
            w_state_nxt = LD_COLLECT;
          end
        end else begin
          w_state_nxt = LD_COLLECT;
        end
      end
      LD_WRITE: begin
        if (!r_ptr[ADDR_W]) begin
          w_we      = 1'b1;
          w_ptr_nxt = r_ptr + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
          w_err_nxt = 1'b1;
        end
        w_byte_cnt_nxt = 2'd0;
        w_asm_nxt      = ZERO_WORD;
        if (r_last) begin
          w_state_nxt = LD_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = LD_COLLECT;
        end
      end
      default: begin
        w_state_nxt = LD_IDLE;
      end
    endcase
  end

  inst_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (w_we),
    .waddr(r_ptr[ADDR_W-1:0]),
    .wdata(r_asm),
    .raddr(addr[ADDR_W+1:2]),
    .rdata(w_rdata)
  );

  assign w_in_range = (addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  assign w_unused   = &{1'b0, addr[1:0]};

  // Fetch mux: disabled or out-of-range fetches return a zero word
  always_comb begin
    if (ce && w_in_range) begin
      inst = w_rdata;
    end else begin
      inst = ZERO_WORD;
    end
  end

  assign ld_ready = (r_state == LD_COLLECT);
  assign busy     = (r_state != LD_IDLE);
  assign ld_done  = r_done;
  assign ld_err   = r_err;
  assign word_cnt = r_ptr;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench: a full-size instance and an ADDR_W=2 instance share all inputs,
// so the small one exercises overflow while the large one keeps the image.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;

  logic [31:0] inst,     s_inst;
  logic        ld_ready, s_ld_ready;
  logic        ld_done,  s_ld_done;
  logic        ld_err,   s_ld_err;
  logic        busy,     s_busy;
  logic [10:0] word_cnt;
  logic [2:0]  s_word_cnt;

  int checks   = 0;
  int failures = 0;

  inst_rom_loader #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .busy(busy),
    .word_cnt(word_cnt)
  );

  inst_rom_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(s_inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(s_ld_ready), .ld_done(s_ld_done), .ld_err(s_ld_err), .busy(s_busy),
    .word_cnt(s_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    while (!ld_ready && n < 8) begin
      tick();
      n++;
    end
    chk("rdy_wait", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   last);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp, input logic [31:0] s_exp);
    ce   = 1'b1;
    addr = a;
    #1;
    chk(tag, inst, exp);
    chk({tag, "_s"}, s_inst, s_exp);
  endtask

  localparam logic [31:0] W0 = 32'h1011_1213;
  localparam logic [31:0] W1 = 32'h1415_1617;
  localparam logic [31:0] W2 = 32'h1819_1A1B;
  localparam logic [31:0] W3 = 32'h1C1D_1E1F;
  localparam logic [31:0] W4 = 32'h2021_2223;

  initial begin
    rst = 1'b0; ce = 1'b0; addr = 32'd0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0; ld_last = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset and idle
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_err",   {31'd0, ld_err},   32'd0);
    chk("rst_wcnt",  {21'd0, word_cnt}, 32'd0);
    chk("rst_inst",  inst,              32'd0);
    ld_valid = 1'b1; ld_byte = 8'h5A;
    tick();
    ld_valid = 1'b0;
    chk("idle_valid_ignored", {31'd0, busy}, 32'd0);

    // Two-word session
    pulse_start();
    chk("collect_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h34, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    chk("rdy_drop", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("rdy_back", {31'd0, ld_ready}, 32'd1);
    chk("wcnt_1",   {21'd0, word_cnt}, 32'd1);
    send_byte(8'h34, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b1);
    chk("done_early", {31'd0, ld_done}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, ld_done}, 32'd1);
    chk("wcnt_2",     {21'd0, word_cnt}, 32'd2);
    chk("busy_end",   {31'd0, busy}, 32'd0);
    tick();
    chk("done_clear", {31'd0, ld_done}, 32'd0);
    fetch("fetch_a0", 32'h0, 32'h3401_0010, 32'h3401_0010);
    fetch("fetch_a4", 32'h4, 32'h3402_0020, 32'h3402_0020);
    fetch("fetch_a6", 32'h6, 32'h3402_0020, 32'h3402_0020);
    ce = 1'b0;
    #1;
    chk("ce_off", inst, 32'd0);

    // Partial word, including read-during-write
    pulse_start();
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    fetch("rdw_old", 32'h0, 32'h3401_0010, 32'h3401_0010);
    tick();
    chk("part_done", {31'd0, ld_done}, 32'd1);
    chk("part_wcnt", {21'd0, word_cnt}, 32'd1);
    fetch("part_word", 32'h0, 32'hABCD_0000, 32'hABCD_0000);

    // Restart mid-word; ld_start beats a same-cycle byte
    pulse_start();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h33;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("restart_wcnt", {21'd0, word_cnt}, 32'd0);
    send_word(32'h4455_6677, 1'b1);
    tick();
    chk("restart_done", {31'd0, ld_done}, 32'd1);
    chk("restart_wcnt1", {21'd0, word_cnt}, 32'd1);
    fetch("restart_w0", 32'h0, 32'h4455_6677, 32'h4455_6677);
    fetch("restart_w1", 32'h4, 32'h3402_0020, 32'h3402_0020);

    // Overflow on the ADDR_W=2 instance
    pulse_start();
    send_word(W0, 1'b0); send_word(W1, 1'b0);
    send_word(W2, 1'b0); send_word(W3, 1'b0);
    tick();
    chk("ovf_err_before", {31'd0, s_ld_err}, 32'd0);
    send_word(W4, 1'b1);
    tick();
    chk("ovf_err",     {31'd0, s_ld_err},   32'd1);
    chk("ovf_wcnt",    {29'd0, s_word_cnt}, 32'd4);
    chk("ovf_done",    {31'd0, s_ld_done},  32'd1);
    chk("big_err",     {31'd0, ld_err},     32'd0);
    chk("big_wcnt",    {21'd0, word_cnt},   32'd5);
    fetch("ovf_m0", 32'h0, W0, W0);
    fetch("ovf_m1", 32'h4, W1, W1);
    fetch("ovf_m2", 32'h8, W2, W2);
    fetch("ovf_m3", 32'hC, W3, W3);
    fetch("ovf_m4", 32'h10, W4, 32'd0);
    pulse_start();
    chk("ovf_err_clear", {31'd0, s_ld_err}, 32'd0);

    // Out of range and asynchronous reset mid-session
    fetch("oor", 32'h0000_1000, 32'd0, 32'd0);
    send_byte(8'h99, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, busy},     32'd0);
    chk("arst_ready", {31'd0, ld_ready}, 32'd0);
    chk("arst_wcnt",  {21'd0, word_cnt}, 32'd0);
    fetch("arst_m0", 32'h0, W0, W0);
    fetch("arst_m4", 32'h10, W4, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
